// File: rtl/elevator_ctrl_if.sv
// rtl/elevator_ctrl_if.sv - call/status bundle between the elevator controller and its surroundings
//   req_i         : one-cycle floor-call pulses, one bit per floor
//   door_hold_i   : door-open hold button (level)
//   floor_o       : current car floor
//   moving_up_o   : car travelling up
//   moving_down_o : car travelling down
//   door_open_o   : door open
//   pending_o     : latched, unserved calls
//   master modport drives the calls, slave modport is the controller
interface elevator_ctrl_if #(
  parameter int FLOORS = 8
) ();
  localparam int FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;

  logic [FLOORS-1:0] req_i;
  logic              door_hold_i;
  logic [FW-1:0]     floor_o;
  logic              moving_up_o;
  logic              moving_down_o;
  logic              door_open_o;
  logic [FLOORS-1:0] pending_o;

  modport master (
    output req_i, door_hold_i,
    input  floor_o, moving_up_o, moving_down_o, door_open_o, pending_o
  );

  modport slave (
    input  req_i, door_hold_i,
    output floor_o, moving_up_o, moving_down_o, door_open_o, pending_o
  );
endinterface

// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - SCAN-ordered car-motion and door controller
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset (released synchronously upstream)
//   bus   : elevator_ctrl_if.slave - calls in, car floor/motion/door/pending status out
module elevator_ctrl #(
  parameter int FLOORS     = 8,
  parameter bit SIMULATION = 1'b0,
  parameter int MOVE_TICKS = 10000,
  parameter int DOOR_TICKS = 10000
) (
  input  logic          clk,
  input  logic          rst_n,
  elevator_ctrl_if.slave bus
);
  localparam int FW   = (FLOORS > 1) ? $clog2(FLOORS) : 1;
  localparam int MT   = SIMULATION ? 4 : MOVE_TICKS;
  localparam int DT   = SIMULATION ? 3 : DOOR_TICKS;
  localparam int TMAX = (MT > DT) ? MT : DT;
  localparam int TW   = $clog2(TMAX);

  localparam logic [TW-1:0] MOVE_LAST = TW'(MT - 1);
  localparam logic [TW-1:0] DOOR_LAST = TW'(DT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic              last_up_q, last_up_d;
  logic              moving_up_q, moving_up_d;
  logic              moving_down_q, moving_down_d;
  logic              door_open_q, door_open_d;

  logic [FLOORS-1:0] clr;
  logic [FLOORS-1:0] blk;
  logic [FW-1:0]     floor_up;
  logic [FW-1:0]     floor_dn;
  logic              up_calls;
  logic              dn_calls;

  function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
    any_above = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i > int'(f) && p[i]) any_above = 1'b1;
    end
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FW-1:0] f);
    any_below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i < int'(f) && p[i]) any_below = 1'b1;
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    timer_d   = timer_q;
    last_up_d = last_up_q;
    clr       = '0;
    blk       = '0;
    floor_up  = floor_q + FW'(1);
    floor_dn  = floor_q - FW'(1);
    up_calls  = any_above(pending_q, floor_q);
    dn_calls  = any_below(pending_q, floor_q);

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (pending_q[floor_q]) begin
          state_d      = DOOR_OPEN;
          clr[floor_q] = 1'b1;
        end else if (up_calls && (!dn_calls || last_up_q)) begin
          state_d = MOVE_UP;
        end else if (dn_calls) begin
          state_d = MOVE_DOWN;
        end
      end

      MOVE_UP: begin
        if (timer_q == MOVE_LAST) begin
          // Arrival: the stop/continue decision looks at the floor being entered.
          floor_d   = floor_up;
          last_up_d = 1'b1;
          timer_d   = '0;
          if (pending_q[floor_up]) begin
            state_d       = DOOR_OPEN;
            clr[floor_up] = 1'b1;
          end else if (!any_above(pending_q, floor_up)) begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      MOVE_DOWN: begin
        if (timer_q == MOVE_LAST) begin
          floor_d   = floor_dn;
          last_up_d = 1'b0;
          timer_d   = '0;
          if (pending_q[floor_dn]) begin
            state_d       = DOOR_OPEN;
            clr[floor_dn] = 1'b1;
          end else if (!any_below(pending_q, floor_dn)) begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      DOOR_OPEN: begin
        // A call for the floor the door is already open at only extends the dwell.
        blk[floor_q] = 1'b1;
        if (bus.door_hold_i || bus.req_i[floor_q]) begin
          timer_d = '0;
        end else if (timer_q == DOOR_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // Service clear beats a same-cycle set only on the bit being served.
    pending_d     = (pending_q | (bus.req_i & ~blk)) & ~clr;
    moving_up_d   = (state_d == MOVE_UP);
    moving_down_d = (state_d == MOVE_DOWN);
    door_open_d   = (state_d == DOOR_OPEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      floor_q       <= '0;
      timer_q       <= '0;
      pending_q     <= '0;
      last_up_q     <= 1'b1;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
      door_open_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      floor_q       <= floor_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      last_up_q     <= last_up_d;
      moving_up_q   <= moving_up_d;
      moving_down_q <= moving_down_d;
      door_open_q   <= door_open_d;
    end
  end

  assign bus.floor_o       = floor_q;
  assign bus.moving_up_o   = moving_up_q;
  assign bus.moving_down_o = moving_down_q;
  assign bus.door_open_o   = door_open_q;
  assign bus.pending_o     = pending_q;
endmodule

// File: doc/elevator_ctrl.md
Name: elevator_ctrl

Overview:
- Car-motion and door controller for the elevator.
- Sits directly downstream of the delayed-reset generator. That generator's registered active-low `reset_n` output drives this block's `rst_n`.
- Latches debounced floor-call pulses and moves the car one floor per MOVE_TICKS clocks using SCAN (elevator-algorithm) ordering.
- Opens the door for DOOR_TICKS clocks at each served floor.

Parameters:
- FLOORS, 8: number of floors (2..16); floor index width FW = $clog2(FLOORS).
- SIMULATION, 1'b0: when 1, timer lengths are forced to MOVE_TICKS=4 and DOOR_TICKS=3.
- MOVE_TICKS, 10000: clocks to travel one floor (>=2).
- DOOR_TICKS, 10000: clocks the door stays open (>=2).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset, driven by the delayed-reset generator's `reset_n`.
- req_i  input  FLOORS  one-cycle call pulses, one bit per floor, synchronous and debounced.
- door_hold_i  input  1  door-open hold button, level.
- floor_o  output  FW  current car floor.
- moving_up_o  output  1  car travelling up.
- moving_down_o  output  1  car travelling down.
- door_open_o  output  1  door open.
- pending_o  output  FLOORS  latched, unserved calls.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, floor_o=0, pending_o=0, all status outputs 0, timer=0, last_dir=UP.
  - Release is synchronous to clk via the upstream generator; no internal synchroniser.
- Timer: single counter, width $clog2(max(MOVE_TICKS,DOOR_TICKS)). Cleared on every state entry.
- Call latch: pending[i] <= 1 on the cycle after req_i[i]=1. Exceptions:
  - A request for floor_o while in DOOR_OPEN is not latched; it restarts the door timer.
  - On a cycle where bit i is being cleared for service, the clear wins for that bit only.
  - Set wins on all other bits.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. Outputs are registered, one-hot to state:
  - MOVE_UP: moving_up_o=1.
  - MOVE_DOWN: moving_down_o=1.
  - DOOR_OPEN: door_open_o=1.
- IDLE (evaluates the pending register, not req_i):
  - pending[floor] -> DOOR_OPEN, clear that bit.
  - Else, if calls exist in both directions, go the last_dir way.
  - Else go toward the only direction that has a call.
  - Else stay IDLE.
  - Resulting latency: req pulse at cycle t, pending at t+1, state/outputs change at t+2.
- MOVE_UP:
  - Timer counts 0..MOVE_TICKS-1. On terminal count: floor_o <= floor_o+1 and last_dir=UP.
  - Same-edge decision on the new floor f+1:
    - pending[f+1] -> DOOR_OPEN, clear the bit.
    - Else, any pending above f+1 -> stay MOVE_UP, timer=0.
    - Else -> IDLE.
  - floor_o never exceeds FLOORS-1, because MOVE_UP is only entered or retained with a call above.
- MOVE_DOWN: mirror image of MOVE_UP. floor_o decrements, last_dir=DOWN, never below 0.
- Calls latched mid-move are honoured at the next arrival decision. A call for the floor just left is served after the sweep, by reversal.
- DOOR_OPEN:
  - Timer counts 0..DOOR_TICKS-1, then goes to IDLE. door_open_o is high exactly DOOR_TICKS cycles if undisturbed.
  - door_hold_i=1 or req_i[floor_o]=1 holds the timer at 0.
  - Exit occurs DOOR_TICKS cycles after the last hold or request cycle.
  - The car never moves while door_open_o=1.
- Out-of-range: req_i bits are exactly FLOORS wide, so no invalid floor exists.

Test Plan (SIMULATION=1, FLOORS=8):
- Reset then idle: release rst_n, no requests -> floor_o=0, all status outputs 0, pending_o=0 indefinitely.
- Call at current floor: req_i=8'h01 at cycle t -> pending_o=8'h01 at t+1. At t+2, door_open_o=1 and pending_o=0. door_open_o stays high 3 cycles, then the block returns to IDLE.
- Travel up: at floor 0, req_i=8'h08 -> moving_up_o rises. floor_o steps 1, 2, 3 every 4 cycles. At floor 3, door_open_o=1 for 3 cycles and pending_o=0.
- SCAN ordering: car moving up at floor 2 with pending 8'h20 when req_i=8'h02 arrives -> car serves floor 5 first, then reverses. moving_down_o=1 and the car stops at floor 1. Final pending_o=0.
- Door hold and re-request: during DOOR_OPEN at floor 3, hold door_hold_i for 5 cycles, then pulse req_i=8'h08 once -> door_open_o stays high until 3 cycles after the pulse. pending_o[3] is never set.
- Reset mid-move: assert rst_n=0 while moving_down_o=1 at floor 4 with pending 8'h81 -> outputs drop immediately, without waiting for a clk edge: floor_o=0, pending_o=0, IDLE.
